// File: rtl/rv32i_ctrl_pkg.sv
// Shared RV32I control definitions: sequencer states, opcodes, and the ALU
// operation encoding that the datapath ALU decodes as well.
package rv32i_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_ALUWB,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from funct3 / instr[30] / R-type flag.
// Purely combinational, zero latency, no flow control.
module alu_decoder
   import rv32i_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       bit30,
   input  logic       is_rtype,
   output logic [3:0] alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         3'b000: alu_op = (is_rtype && bit30) ? ALU_SUB : ALU_ADD;
         3'b001: alu_op = ALU_SLL;
         3'b010: alu_op = ALU_SLT;
         3'b011: alu_op = ALU_SLTU;
         3'b100: alu_op = ALU_XOR;
         // immediate shifts carry the arithmetic flag in the same bit as R-type
         3'b101: alu_op = bit30 ? ALU_SRA : ALU_SRL;
         3'b110: alu_op = ALU_OR;
         3'b111: alu_op = ALU_AND;
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: 4 cycles ALU/store, 5 cycles load, plus one
// cycle per memory stall; holds memreq until mem_ready, counts retired instrs.
module multicycle_control_fsm
   import rv32i_ctrl_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr,
   input  logic                 mem_ready,
   output logic                 memreq,
   output logic                 irwe,
   output logic                 pcwe,
   output logic                 regwe,
   output logic                 dmemwe,
   output logic                 rs2sel,
   output logic                 regsel,
   output logic [3:0]           ALUControl,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   state_t     state, state_n;
   logic [6:0] opcode;
   logic       is_rtype;
   logic [3:0] alu_dec;
   logic       retire;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign is_rtype     = (opcode == OP_R);
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   alu_decoder u_alu_decoder (
      .funct3   (instr[14:12]),
      .bit30    (instr[30]),
      .is_rtype (is_rtype),
      .alu_op   (alu_dec)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_FETCH:    if (mem_ready) state_n = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_R || opcode == OP_I)          state_n = S_EXECUTE;
            else if (opcode == OP_LOAD || opcode == OP_STORE) state_n = S_MEMADR;
            else                                           state_n = S_FETCH;
         end
         S_EXECUTE:  state_n = S_ALUWB;
         S_ALUWB:    state_n = S_FETCH;
         S_MEMADR:   state_n = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
         S_MEMWB:    state_n = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
         default:    state_n = S_FETCH;
      endcase
   end

   // Reset forces every output low, so an aborted access never writes.
   always_comb begin
      memreq     = 1'b0;
      irwe       = 1'b0;
      pcwe       = 1'b0;
      regwe      = 1'b0;
      dmemwe     = 1'b0;
      rs2sel     = 1'b0;
      regsel     = 1'b0;
      ALUControl = ALU_ADD;
      illegal    = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               memreq = 1'b1;
               irwe   = mem_ready;
               pcwe   = mem_ready;
            end
            S_DECODE: begin
               illegal = !(opcode == OP_R || opcode == OP_I ||
                           opcode == OP_LOAD || opcode == OP_STORE);
            end
            S_EXECUTE: begin
               ALUControl = alu_dec;
               rs2sel     = !is_rtype;
            end
            S_ALUWB: begin
               ALUControl = alu_dec;
               rs2sel     = !is_rtype;
               regwe      = 1'b1;
            end
            S_MEMADR: begin
               rs2sel = 1'b1;
            end
            S_MEMREAD: begin
               memreq = 1'b1;
               rs2sel = 1'b1;
            end
            S_MEMWB: begin
               regwe  = 1'b1;
               regsel = 1'b1;
            end
            S_MEMWRITE: begin
               memreq = 1'b1;
               dmemwe = 1'b1;
               rs2sel = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign retire = (state == S_ALUWB) || (state == S_MEMWB) ||
                   (state == S_MEMWRITE && mem_ready);

   always_ff @(posedge clk) begin
      if (reset)       instret <= '0;
      else if (retire) instret <= instret + 1'b1;
   end

endmodule
